// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The master modport belongs to the stream source, the slave modport to the loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles big-endian words, writes them to CS_RISC
// instruction memory and releases cpu_reset only after a frame with a good XOR checksum.
module program_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             cpu_reset,
    output logic             done,
    output logic             error
);
    localparam int WIDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_DATA, ST_CHECK, ST_DONE, ST_ERR
    } state_t;

    state_t                state_r, state_next_s;
    logic [7:0]            acc_r, acc_next_s;
    logic [15:0]           len_r, len_next_s;
    logic [1:0]            byte_cnt_r, byte_next_s;
    logic [WIDX_W-1:0]     word_cnt_r, word_next_s;
    logic [23:0]           shift_r, shift_next_s;
    logic                  we_r, we_next_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_next_s;
    logic [31:0]           wdata_r, wdata_next_s;
    logic                  in_ready_r, done_r, error_r, cpu_reset_r;
    logic                  accept_s;
    logic [15:0]           len_full_s;
    logic [WIDX_W-1:0]     word_inc_s;

    // Byte address of a word index, truncated to the memory address width.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [WIDX_W-1:0] idx);
        logic [31:0] full;
        full = 32'(idx) << 2'd2;
        return full[ADDR_WIDTH-1:0];
    endfunction

    assign accept_s   = bus.in_valid && in_ready_r;
    assign len_full_s = {len_r[15:8], bus.in_data};
    assign word_inc_s = word_cnt_r + WIDX_W'(1);

    // Next-state and datapath update for every accepted byte.
    always_comb begin
        state_next_s = state_r;
        acc_next_s   = acc_r;
        len_next_s   = len_r;
        byte_next_s  = byte_cnt_r;
        word_next_s  = word_cnt_r;
        shift_next_s = shift_r;
        we_next_s    = 1'b0;
        addr_next_s  = addr_r;
        wdata_next_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    len_next_s   = {bus.in_data, 8'h00};
                    acc_next_s   = bus.in_data;
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_next_s  = len_full_s;
                    acc_next_s  = acc_r ^ bus.in_data;
                    byte_next_s = 2'd0;
                    word_next_s = '0;
                    if (len_full_s == 16'd0) begin
                        state_next_s = ST_CHECK;
                    end else if (32'(len_full_s) > 32'(MAX_WORDS)) begin
                        state_next_s = ST_ERR;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    acc_next_s   = acc_r ^ bus.in_data;
                    shift_next_s = {shift_r[15:0], bus.in_data};
                    byte_next_s  = byte_cnt_r + 2'd1;
                    if (byte_cnt_r == 2'd3) begin
                        we_next_s    = 1'b1;
                        wdata_next_s = {shift_r, bus.in_data};
                        addr_next_s  = word_addr(word_cnt_r);
                        word_next_s  = word_inc_s;
                        // The strobe lands on the same edge CHECK is entered, so the
                        // last word is in memory before the CHK byte can complete.
                        if (16'(word_inc_s) == len_r) begin
                            state_next_s = ST_CHECK;
                        end else begin
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    state_next_s = (bus.in_data == acc_r) ? ST_DONE : ST_ERR;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_IDLE;
                    acc_next_s   = 8'h00;
                    len_next_s   = 16'h0000;
                    byte_next_s  = 2'd0;
                    word_next_s  = '0;
                    shift_next_s = 24'h000000;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r       <= 8'h00;
            len_r       <= 16'h0000;
            byte_cnt_r  <= 2'd0;
            word_cnt_r  <= '0;
            shift_r     <= 24'h000000;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            in_ready_r  <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            cpu_reset_r <= 1'b1;
        end else begin
            acc_r       <= acc_next_s;
            len_r       <= len_next_s;
            byte_cnt_r  <= byte_next_s;
            word_cnt_r  <= word_next_s;
            shift_r     <= shift_next_s;
            we_r        <= we_next_s;
            addr_r      <= addr_next_s;
            wdata_r     <= wdata_next_s;
            in_ready_r  <= (state_next_s != ST_DONE) && (state_next_s != ST_ERR);
            done_r      <= (state_next_s == ST_DONE);
            error_r     <= (state_next_s == ST_ERR);
            cpu_reset_r <= (state_next_s != ST_DONE);
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.imem_we    = we_r;
    assign bus.imem_addr  = addr_r;
    assign bus.imem_wdata = wdata_r;
    assign cpu_reset      = cpu_reset_r;
    assign done           = done_r;
    assign error          = error_r;
endmodule
